i2c_apb_regfile_v2: RTL and testbench

Parametrised APB3 register file sitting between the APB bus and the I2C core/FIFOs. It is the next generation of the team's I2C register block. It adds:
- configurable prescaler, data and address widths
- wait-state and error handshake (pready/pslverr)
- single-cycle FIFO push/pop strobes
- FIFO level readback
- a maskable interrupt block with write-1-to-clear (W1C) status

---
 rtl/i2c_regs_pkg.sv | 55 +++++
 rtl/i2c_irq_ctrl.sv | 56 +++++
 rtl/i2c_apb_regfile_v2.sv | 155 +++++++++++++++
 tb/tb_i2c_apb_regfile_v2.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_regs_pkg.sv
// ---------------------------------------------------------------
// i2c_regs_pkg : register map, IRQ bit indices and address decode
// Rev 2.0
// ---------------------------------------------------------------
`default_nettype none

package i2c_regs_pkg;

  localparam logic [7:0] ADDR_PRESC    = 8'h00;
  localparam logic [7:0] ADDR_CMD      = 8'h01;
  localparam logic [7:0] ADDR_TX       = 8'h02;
  localparam logic [7:0] ADDR_RX       = 8'h03;
  localparam logic [7:0] ADDR_ADDR     = 8'h04;
  localparam logic [7:0] ADDR_STATUS   = 8'h05;
  localparam logic [7:0] ADDR_IRQ_EN   = 8'h06;
  localparam logic [7:0] ADDR_IRQ_STAT = 8'h07;
  localparam logic [7:0] ADDR_LEVEL    = 8'h08;

  localparam int IRQ_TX_EMPTY = 0;
  localparam int IRQ_RX_AVAIL = 1;
  localparam int IRQ_STOP     = 2;
  localparam int IRQ_RX_OVF   = 3;
  localparam int IRQ_W        = 4;

  localparam int         CMD_EN_BIT = 6;
  localparam logic [7:0] CMD_RST    = 8'h04;

  typedef enum logic [3:0] {
    SEL_PRESC, SEL_CMD, SEL_TX, SEL_RX, SEL_ADDR,
    SEL_STATUS, SEL_IRQ_EN, SEL_IRQ_STAT, SEL_LEVEL, SEL_NONE
  } reg_sel_e;

  // Full-width compare so aliases above 0xFF decode as unmapped.
  function automatic reg_sel_e decode_addr(input logic [31:0] a);
    case (a)
      32'(ADDR_PRESC):    return SEL_PRESC;
      32'(ADDR_CMD):      return SEL_CMD;
      32'(ADDR_TX):       return SEL_TX;
      32'(ADDR_RX):       return SEL_RX;
      32'(ADDR_ADDR):     return SEL_ADDR;
      32'(ADDR_STATUS):   return SEL_STATUS;
      32'(ADDR_IRQ_EN):   return SEL_IRQ_EN;
      32'(ADDR_IRQ_STAT): return SEL_IRQ_STAT;
      32'(ADDR_LEVEL):    return SEL_LEVEL;
      default:            return SEL_NONE;
    endcase
  endfunction

  function automatic logic is_read_only(input reg_sel_e s);
    return (s == SEL_RX) || (s == SEL_STATUS) || (s == SEL_LEVEL);
  endfunction

endpackage

`default_nettype wire

// File: rtl/i2c_irq_ctrl.sv
// ---------------------------------------------------------------
// i2c_irq_ctrl : edge-detected IRQ sources, W1C status, registered irq
// Rev 2.0
// ---------------------------------------------------------------
`default_nettype none

module i2c_irq_ctrl
  import i2c_regs_pkg::*;
#(
  parameter int LVL_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [LVL_W-1:0] tx_level,
  input  logic             rx_empty,
  input  logic             stop,
  input  logic             rx_ovf,
  input  logic [IRQ_W-1:0] irq_en,
  input  logic [IRQ_W-1:0] w1c,
  output logic [IRQ_W-1:0] irq_stat,
  output logic             irq
);

  logic             tx_zero;
  logic             tx_zero_q;
  logic             rx_empty_q;
  logic [IRQ_W-1:0] set_evt;

  assign tx_zero = (tx_level == '0);

  always_comb begin
    set_evt               = '0;
    set_evt[IRQ_TX_EMPTY] = tx_zero & ~tx_zero_q;
    set_evt[IRQ_RX_AVAIL] = rx_empty_q & ~rx_empty;
    set_evt[IRQ_STOP]     = stop;
    set_evt[IRQ_RX_OVF]   = rx_ovf;
  end

  // History resets to "empty" so leaving reset never looks like an edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_zero_q  <= 1'b1;
      rx_empty_q <= 1'b1;
      irq_stat   <= '0;
      irq        <= 1'b0;
    end else begin
      tx_zero_q  <= tx_zero;
      rx_empty_q <= rx_empty;
      irq_stat   <= (irq_stat & ~w1c) | set_evt;
      irq        <= |(irq_stat & irq_en);
    end
  end

endmodule

`default_nettype wire

// File: rtl/i2c_apb_regfile_v2.sv
// ---------------------------------------------------------------
// i2c_apb_regfile_v2 : APB3 register file for the I2C core and FIFOs
// Rev 2.0
// ---------------------------------------------------------------
`default_nettype none

module i2c_apb_regfile_v2
  import i2c_regs_pkg::*;
#(
  parameter int ADDR_W    = 8,
  parameter int DATA_W    = 8,
  parameter int PRESC_W   = 16,
  parameter int PRESC_RST = 4,
  parameter int FIFO_AW   = 4,
  parameter int WAIT_MAX  = 15
) (
  input  logic               pclk_i,
  input  logic               preset_n_i,
  input  logic               psel_i,
  input  logic               penable_i,
  input  logic               pwrite_i,
  input  logic [ADDR_W-1:0]  paddr_i,
  input  logic [31:0]        pwdata_i,
  output logic [31:0]        prdata_o,
  output logic               pready_o,
  output logic               pslverr_o,
  input  logic               stop_cnt_i,
  input  logic [7:0]         status_i,
  input  logic [DATA_W-1:0]  rx_data_i,
  input  logic               rx_empty_i,
  input  logic               tx_full_i,
  input  logic [FIFO_AW:0]   tx_level_i,
  input  logic [FIFO_AW:0]   rx_level_i,
  input  logic               rx_ovf_i,
  output logic [PRESC_W-1:0] prescaler_o,
  output logic [7:0]         cmd_o,
  output logic [7:0]         address_rw_o,
  output logic [DATA_W-1:0]  tx_data_o,
  output logic               tx_push_o,
  output logic               rx_pop_o,
  output logic               irq_o
);

  localparam int WCW = (WAIT_MAX < 1) ? 1 : $clog2(WAIT_MAX + 1);

  reg_sel_e         sel;
  logic             access;
  logic             dec_err;
  logic             blocked;
  logic             timeout;
  logic             done_ok;
  logic             wr_en;
  logic [WCW-1:0]   wait_cnt;
  logic [7:0]       cmd_next;
  logic [IRQ_W-1:0] irq_en;
  logic [IRQ_W-1:0] irq_stat;
  logic [IRQ_W-1:0] w1c;
  logic [31:0]      rd_mux;
  logic             unused_bits;

  assign sel = decode_addr(32'(paddr_i));

  // Gating with reset releases a stalled access as soon as reset asserts.
  assign access  = psel_i & penable_i & preset_n_i;
  assign dec_err = (sel == SEL_NONE) | (pwrite_i & is_read_only(sel));
  assign blocked = ~dec_err &
                   (( pwrite_i & (sel == SEL_TX) & tx_full_i) |
                    (~pwrite_i & (sel == SEL_RX) & rx_empty_i));
  assign timeout = blocked & (wait_cnt == WCW'(WAIT_MAX));

  assign pready_o  = ~(access & blocked & ~timeout);
  assign pslverr_o = access & (dec_err | timeout);
  assign done_ok   = access & pready_o & ~pslverr_o;
  assign wr_en     = done_ok & pwrite_i;
  assign tx_push_o = wr_en & (sel == SEL_TX);
  assign rx_pop_o  = done_ok & ~pwrite_i & (sel == SEL_RX);

  always_ff @(posedge pclk_i or negedge preset_n_i) begin
    if (!preset_n_i) begin
      wait_cnt <= '0;
    end else if (!psel_i || (access && pready_o)) begin
      wait_cnt <= '0;
    end else if (access && blocked) begin
      wait_cnt <= wait_cnt + WCW'(1);
    end
  end

  // A stop pulse only overrides the EN bit; the rest of a CMD write lands.
  always_comb begin
    cmd_next = cmd_o;
    if (wr_en && sel == SEL_CMD) cmd_next = pwdata_i[7:0];
    if (stop_cnt_i) cmd_next[CMD_EN_BIT] = 1'b0;
  end

  always_ff @(posedge pclk_i or negedge preset_n_i) begin
    if (!preset_n_i) begin
      prescaler_o  <= PRESC_W'(PRESC_RST);
      cmd_o        <= CMD_RST;
      address_rw_o <= '0;
      tx_data_o    <= '0;
      irq_en       <= '0;
    end else begin
      cmd_o <= cmd_next;
      if (wr_en) begin
        case (sel)
          SEL_PRESC:  prescaler_o  <= pwdata_i[PRESC_W-1:0];
          SEL_TX:     tx_data_o    <= pwdata_i[DATA_W-1:0];
          SEL_ADDR:   address_rw_o <= pwdata_i[7:0];
          SEL_IRQ_EN: irq_en       <= pwdata_i[IRQ_W-1:0];
          default:    ;
        endcase
      end
    end
  end

  assign w1c = (wr_en && sel == SEL_IRQ_STAT) ? pwdata_i[IRQ_W-1:0] : '0;

  i2c_irq_ctrl #(
    .LVL_W (FIFO_AW + 1)
  ) u_irq (
    .clk      (pclk_i),
    .rst_n    (preset_n_i),
    .tx_level (tx_level_i),
    .rx_empty (rx_empty_i),
    .stop     (stop_cnt_i),
    .rx_ovf   (rx_ovf_i),
    .irq_en   (irq_en),
    .w1c      (w1c),
    .irq_stat (irq_stat),
    .irq      (irq_o)
  );

  always_comb begin
    rd_mux = '0;
    case (sel)
      SEL_PRESC:    rd_mux = 32'(prescaler_o);
      SEL_CMD:      rd_mux = 32'(cmd_o);
      SEL_TX:       rd_mux = 32'(tx_data_o);
      SEL_RX:       rd_mux = 32'(rx_data_i);
      SEL_ADDR:     rd_mux = 32'(address_rw_o);
      SEL_STATUS:   rd_mux = 32'(status_i);
      SEL_IRQ_EN:   rd_mux = 32'(irq_en);
      SEL_IRQ_STAT: rd_mux = 32'(irq_stat);
      SEL_LEVEL:    rd_mux = (32'(rx_level_i) << 16) | 32'(tx_level_i);
      default:      rd_mux = '0;
    endcase
  end

  assign prdata_o = (access && !pwrite_i && !pslverr_o) ? rd_mux : 32'h0;

  assign unused_bits = ^pwdata_i;

endmodule

`default_nettype wire

// File: tb/tb_i2c_apb_regfile_v2.sv
// ---------------------------------------------------------------
// tb_i2c_apb_regfile_v2 : scoreboard bench for the APB I2C register file
// Rev 2.0
// ---------------------------------------------------------------
`default_nettype none

module tb_i2c_apb_regfile_v2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        psel, penable, pwrite;
  logic [7:0]  paddr;
  logic [31:0] pwdata, prdata;
  logic        pready, pslverr;
  logic        stop_cnt;
  logic [7:0]  status;
  logic [7:0]  rx_data;
  logic        rx_empty, tx_full, rx_ovf;
  logic [4:0]  tx_level, rx_level;
  logic [15:0] prescaler;
  logic [7:0]  cmd, address_rw, tx_data;
  logic        tx_push, rx_pop, irq;

  always #5 clk = ~clk;

  i2c_apb_regfile_v2 dut (
    .pclk_i       (clk),
    .preset_n_i   (rst_n),
    .psel_i       (psel),
    .penable_i    (penable),
    .pwrite_i     (pwrite),
    .paddr_i      (paddr),
    .pwdata_i     (pwdata),
    .prdata_o     (prdata),
    .pready_o     (pready),
    .pslverr_o    (pslverr),
    .stop_cnt_i   (stop_cnt),
    .status_i     (status),
    .rx_data_i    (rx_data),
    .rx_empty_i   (rx_empty),
    .tx_full_i    (tx_full),
    .tx_level_i   (tx_level),
    .rx_level_i   (rx_level),
    .rx_ovf_i     (rx_ovf),
    .prescaler_o  (prescaler),
    .cmd_o        (cmd),
    .address_rw_o (address_rw),
    .tx_data_o    (tx_data),
    .tx_push_o    (tx_push),
    .rx_pop_o     (rx_pop),
    .irq_o        (irq)
  );

  typedef struct {
    logic        is_read;
    logic [31:0] rdata;
    logic        err;
    int          waits;
    logic        strobe;
  } exp_t;

  exp_t sb[$];
  int   n_chk = 0;
  int   n_pass = 0;
  int   waits_seen = 0;
  int   stray = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  // Completion monitor: pops the scoreboard on every finished access.
  always @(negedge clk) begin
    if (rst_n && psel && penable) begin
      if (!pready) begin
        waits_seen++;
        if (tx_push || rx_pop) stray++;
      end else if (sb.size() == 0) begin
        chk("sb_underflow", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("pslverr", 32'(pslverr), 32'(e.err));
        if (e.is_read) chk("prdata", prdata, e.rdata);
        chk("wait_states", 32'(waits_seen), 32'(e.waits));
        chk("strobe", 32'(tx_push | rx_pop), 32'(e.strobe));
        waits_seen = 0;
      end
    end else if (tx_push || rx_pop) begin
      stray++;
    end
  end

  task automatic apb(input logic wr, input logic [7:0] a, input logic [31:0] wd,
                     input logic [31:0] rd_exp, input logic err_exp,
                     input int waits_exp, input logic strobe_exp);
    bit done;
    sb.push_back('{is_read: !wr, rdata: rd_exp, err: err_exp,
                   waits: waits_exp, strobe: strobe_exp});
    psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pwdata = wd;
    @(posedge clk); #1 penable = 1'b1;
    done = 1'b0;
    for (int i = 0; i < 64 && !done; i++) begin
      @(negedge clk);
      if (pready) done = 1'b1;
    end
    if (!done) chk("apb_timeout", 32'd0, 32'd1);
    @(posedge clk); #1 psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
  endtask

  task automatic rd(input logic [7:0] a, input logic [31:0] e);
    apb(1'b0, a, 32'h0, e, 1'b0, 0, 1'b0);
  endtask

  task automatic wr(input logic [7:0] a, input logic [31:0] d);
    apb(1'b1, a, d, 32'h0, 1'b0, 0, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    paddr = '0; pwdata = '0; stop_cnt = 1'b0; status = 8'h81;
    rx_data = 8'h00; rx_empty = 1'b1; tx_full = 1'b0; rx_ovf = 1'b0;
    tx_level = '0; rx_level = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_pready", 32'(pready), 32'd1);
    chk("rst_pslverr", 32'(pslverr), 32'd0);
    chk("rst_prdata", prdata, 32'd0);
    chk("rst_irq", 32'(irq), 32'd0);
    chk("rst_cmd", 32'(cmd), 32'h04);
    chk("rst_presc", 32'(prescaler), 32'h4);
    chk("rst_txdata", 32'(tx_data), 32'h0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;

    rd(8'h00, 32'h4);
    rd(8'h01, 32'h04);
    chk("irq_idle", 32'(irq), 32'd0);

    // TX push without and with back-pressure
    apb(1'b1, 8'h02, 32'hFFFF_FFA5, 32'h0, 1'b0, 0, 1'b1);
    chk("tx_data_a5", 32'(tx_data), 32'hA5);
    tx_full = 1'b1;
    fork
      apb(1'b1, 8'h02, 32'h3C, 32'h0, 1'b0, 3, 1'b1);
      begin repeat (4) @(posedge clk); #1 tx_full = 1'b0; end
    join
    chk("tx_data_3c", 32'(tx_data), 32'h3C);
    tx_full = 1'b1;
    apb(1'b1, 8'h02, 32'h77, 32'h0, 1'b1, 15, 1'b0);
    chk("tx_data_kept", 32'(tx_data), 32'h3C);
    tx_full = 1'b0;

    // CMD.EN cleared by a coincident stop pulse
    fork
      wr(8'h01, 32'h40);
      begin @(posedge clk); #1 stop_cnt = 1'b1; @(posedge clk); #1 stop_cnt = 1'b0; end
    join
    chk("cmd_stop", 32'(cmd), 32'h00);
    wr(8'h01, 32'h44);
    chk("cmd_44", 32'(cmd), 32'h44);
    rd(8'h01, 32'h44);

    wr(8'h00, 32'hABCD_1234);
    chk("presc", 32'(prescaler), 32'h1234);
    wr(8'h04, 32'hA7);
    rd(8'h04, 32'hA7);
    chk("addr_rw", 32'(address_rw), 32'hA7);

    // RX pop stalls out on an empty FIFO
    apb(1'b0, 8'h03, 32'h0, 32'h0, 1'b1, 15, 1'b0);

    // Interrupt on RX data becoming available
    wr(8'h06, 32'h2);
    wr(8'h07, 32'hF);
    rd(8'h07, 32'h0);
    rx_data = 8'h5A; rx_level = 5'd1; rx_empty = 1'b0;
    @(negedge clk); chk("irq_pre", 32'(irq), 32'd0);
    @(posedge clk);
    @(negedge clk); chk("irq_latency", 32'(irq), 32'd0);
    @(posedge clk);
    @(negedge clk); chk("irq_set", 32'(irq), 32'd1);
    @(posedge clk); #1;
    rd(8'h07, 32'h2);
    apb(1'b0, 8'h03, 32'h0, 32'h5A, 1'b0, 0, 1'b1);
    wr(8'h07, 32'h2);
    @(posedge clk);
    @(negedge clk); chk("irq_cleared", 32'(irq), 32'd0);
    rx_empty = 1'b1;
    @(posedge clk); #1;
    fork
      wr(8'h07, 32'h2);
      begin @(posedge clk); #1 rx_empty = 1'b0; end
    join
    rd(8'h07, 32'h2);
    chk("irq_set_wins", 32'(irq), 32'd1);

    // Level readback and TX-empty / overflow sources
    wr(8'h07, 32'hF);
    tx_level = 5'd3; rx_level = 5'd5;
    rd(8'h08, 32'h0005_0003);
    tx_level = 5'd0; rx_ovf = 1'b1;
    @(posedge clk); #1 rx_ovf = 1'b0;
    @(posedge clk); #1;
    rd(8'h07, 32'h9);

    // Decode errors
    apb(1'b0, 8'h09, 32'h0, 32'h0, 1'b1, 0, 1'b0);
    apb(1'b1, 8'h05, 32'hFF, 32'h0, 1'b1, 0, 1'b0);
    apb(1'b1, 8'h09, 32'hFF, 32'h0, 1'b1, 0, 1'b0);
    apb(1'b1, 8'h03, 32'hFF, 32'h0, 1'b1, 0, 1'b0);
    rd(8'h05, 32'h81);
    rd(8'h00, 32'h1234);
    chk("cmd_unchanged", 32'(cmd), 32'h44);
    @(negedge clk);
    chk("idle_prdata", prdata, 32'h0);

    chk("stray_strobes", 32'(stray), 32'd0);
    chk("sb_drain", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule

`default_nettype wire
